uart_tx_buffered: RTL and testbench

- Buffered UART transmitter: a byte FIFO in front of an 8N1 serializer.
- Lets the board/PC bridge logic forward bursts from several receivers without dropping bytes while a frame is on the wire.
- Sits between the bridge control FSM and the TX / board RXD pins.
- Companion to the existing UART receiver (same framing, same baud parameters).

---
 rtl/uart_pkg.sv | 26 ++
 rtl/byte_fifo.sv | 80 ++++++++
 rtl/uart_tx_buffered.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver:
//   - uart_state_t      : serializer/deserializer state encoding
//   - DATA_BITS         : data bits per frame
//   - calc_clks_per_bit : derives the baud divisor from clock and line rate
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } uart_state_t;

   // Integer division truncates, so 32 MHz / 9600 gives 3333 clocks per bit.
   function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Synchronous byte FIFO with first-word fall-through read port.
// Parameters:
//   DEPTH : number of byte entries, power of two, >= 2
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset (empties the FIFO)
//   push  in   write request; ignored while full
//   din   in   byte to write
//   pop   in   read request; ignored while empty
//   dout  out  byte at the head of the FIFO (valid while !empty)
//   full  out  count == DEPTH
//   empty out  count == 0
//   count out  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [7:0]             din,
   input  logic                   pop,
   output logic [7:0]             dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   // A pop in the same cycle does not free a slot for a push while full.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // Head is read combinationally so the consumer can capture it on the pop edge.
   assign dout    = mem[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; emptiness is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
// Buffered UART transmitter: byte FIFO feeding an 8N1 serializer. Frames are
// sent back-to-back with no idle gap while the FIFO holds data.
// Optional build macro:
//   UART_TX_PARITY_EN : adds an even-parity bit between the data bits and the
//                       stop bit (11-bit frame). Undefined: 8N1, 10-bit frame.
// Parameters:
//   CLK_FREQ   : system clock in Hz
//   BAUD_RATE  : line rate in bit/s (clocks per bit = CLK_FREQ/BAUD_RATE)
//   FIFO_DEPTH : FIFO entries, power of two, >= 2
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset; abandons any frame in flight
//   en       in   write strobe; byte accepted when en && rdy at the clock edge
//   data_in  in   byte to queue
//   rdy      out  FIFO not full
//   dout     out  serial line, registered, idles high
//   busy     out  frame in progress or FIFO non-empty
//   level    out  FIFO occupancy
//   overflow out  sticky: en seen while rdy low (byte dropped), cleared by reset
// -----------------------------------------------------------------------------
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 32000000,
   parameter int BAUD_RATE  = 9600,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [7:0]                  data_in,
   output logic                        rdy,
   output logic                        dout,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output logic                        overflow
);

   localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

   uart_state_t state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              dout_q, dout_d;
   logic              overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
   logic              parity_q, parity_d;
`endif

   logic [7:0]                  fifo_dout;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                        baud_last;
   logic                        start_frame;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (en),
      .din   (data_in),
      .pop   (start_frame),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign baud_last = (baud_q == BAUD_LAST);
   // A new frame starts from IDLE, or straight out of the last stop-bit cycle
   // so consecutive frames run without an idle gap.
   assign start_frame = !fifo_empty &&
                        ((state_q == IDLE) || ((state_q == STOP) && baud_last));

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      dout_d     = dout_q;
      overflow_d = overflow_q | (en & fifo_full);
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif

      case (state_q)
         IDLE: begin
            baud_d = '0;
            dout_d = 1'b1;
         end
         START: begin
            if (baud_last) begin
               state_d = DATA;
               baud_d  = '0;
               bit_d   = '0;
               dout_d  = shift_q[0];
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  dout_d  = parity_q;
`else
                  state_d = STOP;
                  dout_d  = 1'b1;
`endif
               end else begin
                  // dout is registered, so the next bit is taken one position up.
                  bit_d   = bit_q + 1'b1;
                  shift_d = {1'b0, shift_q[7:1]};
                  dout_d  = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_last) begin
               state_d = STOP;
               baud_d  = '0;
               dout_d  = 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
`endif
         STOP: begin
            if (baud_last) begin
               state_d = IDLE;
               baud_d  = '0;
               dout_d  = 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
            dout_d  = 1'b1;
         end
      endcase

      // Loading the head overrides the IDLE / end-of-STOP defaults above.
      if (start_frame) begin
         state_d = START;
         baud_d  = '0;
         bit_d   = '0;
         shift_d = fifo_dout;
         dout_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_d = ^fifo_dout;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         dout_q     <= 1'b1;
         overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         dout_q     <= dout_d;
         overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign rdy      = !fifo_full;
   assign dout     = dout_q;
   assign busy     = (state_q != IDLE) || !fifo_empty;
   assign level    = fifo_count;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered
// Stimulus pushes bytes on chosen clock edges and queues the expected frames;
// a line monitor decodes every frame on dout, pops the queue and compares the
// whole frame cycle by cycle. Directed checks cover level/rdy/busy/overflow.
// Cycle numbering: cyc counts rising edges; everything is sampled and driven
// on falling edges, so at a falling edge cyc is the index of the last edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;

   localparam int CLK_FREQ   = 16;
   localparam int BAUD_RATE  = 1;
   localparam int FIFO_DEPTH = 4;
   localparam int CPB        = 16;
`ifdef UART_TX_PARITY_EN
   localparam int SLOTS = 11;
`else
   localparam int SLOTS = 10;
`endif
   localparam int FC = SLOTS * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] data_in;
   logic       rdy;
   logic       dout;
   logic       busy;
   logic [2:0] level;
   logic       overflow;

   typedef struct {
      logic [7:0] data;
      bit         expect_abort;
   } sb_t;

   sb_t exp_q[$];
   int  frame_starts[$];
   int  checks      = 0;
   int  failures    = 0;
   int  cyc         = 0;
   int  frames_done = 0;
   bit  in_frame    = 1'b0;

   uart_tx_buffered #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD_RATE),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .data_in  (data_in),
      .rdy      (rdy),
      .dout     (dout),
      .busy     (busy),
      .level    (level),
      .overflow (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
      end else begin
         $display("ok   %s = %0d (cyc %0d)", name, act, cyc);
      end
   endtask

   task automatic go_to(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Drive en/data_in so the byte is captured at rising edge e_n; returns at
   // the falling edge right after e_n.
   task automatic push_at(input int e_n, input logic [7:0] b, input bit on_line, input bit cut);
      sb_t ent;
      go_to(e_n - 1);
      if (on_line) begin
         ent.data         = b;
         ent.expect_abort = cut;
         exp_q.push_back(ent);
      end
      en      = 1'b1;
      data_in = b;
      @(negedge clk);
      en      = 1'b0;
      $display("push data=%02h at edge %0d", b, e_n);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((busy || in_frame) && n < 4000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checks++;
      if (n >= 4000) begin
         failures++;
         $display("FAIL %s_idle: still busy after %0d cycles, required idle", name, n);
      end
   endtask

   function automatic logic slot_bit(input logic [7:0] d, input int s);
      if (s == 0) return 1'b0;
      if (s <= 8) return d[s-1];
`ifdef UART_TX_PARITY_EN
      if (s == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   // Line monitor: a falling line outside reset is a start bit; the full frame
   // is compared cycle by cycle against the expected pattern.
   initial begin : monitor
      sb_t         ent;
      logic [10:0] exp_pat;
      logic [10:0] got_pat;
      bit          glitch;
      bit          cut;
      bit          unexpected;
      int          st;
      forever begin
         @(negedge clk);
         if (!rst && dout === 1'b0) begin
            in_frame = 1'b1;
            st = cyc;
            frame_starts.push_back(st);
            unexpected = 1'b0;
            if (exp_q.size() == 0) begin
               unexpected = 1'b1;
               checks++;
               failures++;
               $display("FAIL frame_unexpected: start bit at edge %0d, required no frame", st);
               ent.data = 8'h00;
               ent.expect_abort = 1'b0;
            end else begin
               ent = exp_q.pop_front();
            end
            exp_pat = '1;
            got_pat = '1;
            for (int s = 0; s < SLOTS; s++) exp_pat[s] = slot_bit(ent.data, s);
            glitch = 1'b0;
            cut    = 1'b0;
            for (int i = 0; i < FC && !cut; i++) begin
               if (i != 0) @(negedge clk);
               if (rst) begin
                  cut = 1'b1;
               end else begin
                  if (dout !== exp_pat[i / CPB]) glitch = 1'b1;
                  if ((i % CPB) == (CPB / 2)) got_pat[i / CPB] = dout;
               end
            end
            if (!unexpected) begin
               checks++;
               if (cut != ent.expect_abort) begin
                  failures++;
                  $display("FAIL frame_abort data=%02h: aborted=%0d required=%0d", ent.data, cut, ent.expect_abort);
               end else if (!cut && glitch) begin
                  failures++;
                  $display("FAIL frame_bits data=%02h start=%0d: line=%b required=%b (cycle-exact)",
                           ent.data, st, got_pat, exp_pat);
               end else begin
                  $display("frame data=%02h start=%0d %s", ent.data, st, cut ? "cut by reset" : "ok");
               end
               if (!cut) frames_done++;
            end
            in_frame = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int e;
      int s;
      int n0;
      rst     = 1'b1;
      en      = 1'b0;
      data_in = 8'h00;
      repeat (3) @(negedge clk);
      check("reset dout", 32'(dout), 1);
      check("reset busy", 32'(busy), 0);
      check("reset rdy", 32'(rdy), 1);
      check("reset level", 32'(level), 0);
      check("reset overflow", 32'(overflow), 0);
      #2 rst = 1'b0;
      @(negedge clk);

      // Single byte 0xA5: start bit after edge e+1, idle after edge e+1+FC.
      e = cyc + 2;
      push_at(e, 8'hA5, 1, 0);
      check("single level after push", 32'(level), 1);
      check("single dout before start", 32'(dout), 1);
      @(negedge clk);
      check("single dout start bit", 32'(dout), 0);
      check("single level after pop", 32'(level), 0);
      go_to(e + FC);
      check("single busy last stop cycle", 32'(busy), 1);
      go_to(e + FC + 1);
      check("single busy after frame", 32'(busy), 0);
      check("single dout idle", 32'(dout), 1);
      wait_idle("single");

      // Burst 01,02,03 on consecutive edges: the first is popped as the second
      // arrives, so level reads 1,1,2, then drops at each frame boundary.
      n0 = frame_starts.size();
      e = cyc + 2;
      push_at(e, 8'h01, 1, 0);
      check("burst level 1st", 32'(level), 1);
      push_at(e + 1, 8'h02, 1, 0);
      check("burst level 2nd", 32'(level), 1);
      push_at(e + 2, 8'h03, 1, 0);
      check("burst level 3rd", 32'(level), 2);
      go_to(e + 1 + FC);
      check("burst level after 2nd pop", 32'(level), 1);
      go_to(e + 1 + 2 * FC);
      check("burst level after 3rd pop", 32'(level), 0);
      wait_idle("burst");
      check("burst frames", 32'(frame_starts.size() - n0), 3);
      if (frame_starts.size() >= n0 + 3) begin
         check("burst start 1", 32'(frame_starts[n0]), 32'(e + 1));
         check("burst gap 1-2", 32'(frame_starts[n0+1] - frame_starts[n0]), 32'(FC));
         check("burst gap 2-3", 32'(frame_starts[n0+2] - frame_starts[n0+1]), 32'(FC));
      end

      // Full: first byte goes on the wire, four more fill the FIFO, a fifth is dropped.
      e = cyc + 2;
      push_at(e, 8'h10, 1, 0);
      push_at(e + 2, 8'h11, 1, 0);
      push_at(e + 3, 8'h12, 1, 0);
      push_at(e + 4, 8'h13, 1, 0);
      check("full overflow before", 32'(overflow), 0);
      push_at(e + 5, 8'h14, 1, 0);
      check("full level", 32'(level), 4);
      check("full rdy", 32'(rdy), 0);
      push_at(e + 6, 8'h15, 0, 0);
      check("full level after drop", 32'(level), 4);
      check("full overflow", 32'(overflow), 1);
      wait_idle("full");
      check("full rdy after drain", 32'(rdy), 1);
      check("full overflow sticky", 32'(overflow), 1);

      // Push lands on the STOP->START edge that pops the only queued byte.
      n0 = frame_starts.size();
      e = cyc + 2;
      push_at(e, 8'h21, 1, 0);
      s = e + 1;
      push_at(e + 4, 8'h22, 1, 0);
      check("simul level queued", 32'(level), 1);
      go_to(s + FC - 1);
      check("simul level before boundary", 32'(level), 1);
      push_at(s + FC, 8'h23, 1, 0);
      check("simul level after boundary", 32'(level), 1);
      wait_idle("simul");
      check("simul frames", 32'(frame_starts.size() - n0), 3);
      if (frame_starts.size() >= n0 + 3) begin
         check("simul start 2", 32'(frame_starts[n0+1]), 32'(s + FC));
         check("simul start 3", 32'(frame_starts[n0+2]), 32'(s + 2 * FC));
      end

      // Reset during data bit 3 of 0x5A with 0x77 still queued behind it.
      e = cyc + 2;
      push_at(e, 8'h5A, 1, 1);
      s = e + 1;
      push_at(e + 3, 8'h77, 0, 0);
      check("rst level queued", 32'(level), 1);
      go_to(s + 4 * CPB + 6);
      check("rst busy mid-frame", 32'(busy), 1);
      #2 rst = 1'b1;
      #1;
      check("rst async dout", 32'(dout), 1);
      check("rst async busy", 32'(busy), 0);
      check("rst async level", 32'(level), 0);
      check("rst async rdy", 32'(rdy), 1);
      check("rst async overflow", 32'(overflow), 0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      e = cyc + 2;
      push_at(e, 8'h33, 1, 0);
      wait_idle("after reset");

      // Parity reference bytes: 0x07 (odd weight), 0x03 (even weight).
      n0 = frame_starts.size();
      e = cyc + 2;
      push_at(e, 8'h07, 1, 0);
      push_at(e + 1, 8'h03, 1, 0);
      wait_idle("parity");
      if (frame_starts.size() >= n0 + 2)
         check("parity frame length", 32'(frame_starts[n0+1] - frame_starts[n0]), 32'(FC));

      check("scoreboard empty", 32'(exp_q.size()), 0);
      check("frames completed", 32'(frames_done), 15);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
